// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 8-bit, 4-stage pipe front end.
//   ADDR_W / INST_W : PC and instruction widths
//   OP_JMP          : opcode field value of a jump
//   fetch_entry_t   : instruction tagged with the PC it was fetched from
//   jmp_target()    : jump destination, top PC bits of pc+1 joined with the 6-bit immediate
package pipe_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 8;

  localparam logic [1:0] OP_JMP = 2'b11;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] jmp_target(input logic [ADDR_W-1:0] pc_plus1,
                                                   input logic [INST_W-1:0] inst);
    return {pc_plus1[ADDR_W-1:6], inst[5:0]};
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory read port plus the decode handshake.
//   master : the fetch unit (drives imem_req/imem_addr and the inst_* head outputs)
//   slave  : the environment (instruction memory returns imem_rdata, decode drives inst_ready)
interface fetch_prefetch_queue_if;
  import pipe_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer of fetch_entry_t with a registered head.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail (caller guarantees the queue is not full)
//   pop        : remove the head (ignored when empty)
//   head       : current head entry; holds its last value while the queue is empty
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t      mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]     count_next;
  logic              do_pop;
  fetch_entry_t      head_next;

  assign do_pop  = pop && (count != '0);
  assign rd_next = do_pop ? rd_ptr + PW'(1) : rd_ptr;

  // The slot the head moves to can only be the one being written when the
  // queue is (or becomes) empty, so forward the incoming entry in that case.
  assign head_next = (push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];

  always_comb begin
    count_next = count;
    if (push && !do_pop)
      count_next = count + CW'(1);
    else if (!push && do_pop)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0)
        head <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end feeding the IF/ID register.
// Owns the PC, issues reads to a 1-cycle-latency instruction memory, buffers returned
// instructions tagged with their PC, and resolves jumps at fetch (killing the wrong-path read).
//   clk, rst   : clock, asynchronous active-high reset
//   fbus       : fetch_prefetch_queue_if.master (imem_req/imem_addr/imem_rdata,
//                inst_valid/inst_ready/inst_data/inst_pc)
//   DEPTH      : prefetch queue entries (power of two, >= 2); ADDR_W/INST_W from pipe_pkg
// Build option FETCH_PERF_EN adds saturating counters fetch_cnt (enqueues) and
// kill_cnt (dropped returns) as extra output ports.
module fetch_prefetch_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_prefetch_queue_if.master  fbus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]             fetch_cnt,
  output logic [15:0]             kill_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc, rpc, rpc_plus1;
  logic              inflight, kill;
  logic [CW-1:0]     count;
  logic              credit, issue, enq, drop, redirect, pop;
  fetch_entry_t      push_entry, head;

  // Outstanding read counts against queue space so a return always has a slot.
  assign credit    = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
  assign issue     = credit && !rst;
  assign enq       = inflight && !kill;
  assign drop      = inflight && kill;
  assign redirect  = enq && (fbus.imem_rdata[INST_W-1 -: 2] == OP_JMP);
  assign rpc_plus1 = rpc + ADDR_W'(1);
  assign push_entry = {fbus.imem_rdata, rpc};
  assign pop       = fbus.inst_valid && fbus.inst_ready;

  assign fbus.imem_req   = issue;
  assign fbus.imem_addr  = pc;
  assign fbus.inst_valid = (count != '0);
  assign fbus.inst_data  = head.inst;
  assign fbus.inst_pc    = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      rpc      <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue)
        rpc <= pc;
      if (redirect)
        pc <= jmp_target(rpc_plus1, fbus.imem_rdata);
      else if (issue)
        pc <= pc + ADDR_W'(1);
      // A read issued alongside the redirect was sequential, i.e. wrong path.
      if (drop)
        kill <= 1'b0;
      else if (redirect && issue)
        kill <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (enq && (fetch_cnt != 16'hFFFF))
        fetch_cnt <= fetch_cnt + 16'd1;
      if (drop && (kill_cnt != 16'hFFFF))
        kill_cnt <= kill_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: program-flow scoreboard plus directed
// reset, straight-line, back-pressure, jump and wrap scenarios and a randomized run.
module tb_fetch_prefetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if bif();

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt, kill_cnt;
`endif

  fetch_prefetch_queue #(.DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .fbus (bif)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  int   ready_mode;          // 0: hold off, 1: always ready, 2: random
  int   cyc, pops, reqs;
  logic [7:0] exp_pc;
  logic prev_valid, prev_ready;
  logic [7:0] prev_data, prev_pc;
  logic any_pop;
  logic [7:0] last_data, last_pc;

  logic       log_valid [64];
  logic       log_req   [64];
  logic [7:0] log_pc    [64];
  logic [7:0] log_data  [64];
  logic [7:0] log_addr  [64];
  logic [7:0] pop_pc_q [$];

  logic [7:0] wrap_exp [6] = '{8'h00, 8'h3F, 8'h7F, 8'hBF, 8'hFF, 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural program flow: next PC after executing inst at p.
  function automatic logic [7:0] next_flow(input logic [7:0] p, input logic [7:0] inst);
    logic [7:0] seq;
    seq = p + 8'd1;
    if (inst[7:6] == 2'b11)
      return (seq & 8'hC0) | (inst & 8'h3F);
    return seq;
  endfunction

  // Instruction memory: data appears the cycle after a request.
  initial begin
    logic       s_req;
    logic [7:0] s_addr;
    bif.imem_rdata = '0;
    forever begin
      @(negedge clk);
      s_req  = bif.imem_req;
      s_addr = bif.imem_addr;
      @(posedge clk);
      #1;
      bif.imem_rdata = s_req ? mem[s_addr] : 8'($urandom);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    logic       v, r;
    logic [7:0] d, p;
    @(negedge clk);
    v = bif.inst_valid;
    d = bif.inst_data;
    p = bif.inst_pc;
    if (bif.imem_req) reqs++;
    if (cyc < 64) begin
      log_valid[cyc] = v;
      log_pc[cyc]    = p;
      log_data[cyc]  = d;
      log_req[cyc]   = bif.imem_req;
      log_addr[cyc]  = bif.imem_addr;
    end
    if (prev_valid && !prev_ready) begin
      chk("hold_valid", 32'(v), 32'd1);
      chk("hold_data", 32'(d), 32'(prev_data));
      chk("hold_pc", 32'(p), 32'(prev_pc));
    end
    if (!v) begin
      chk("idle_data", 32'(d), 32'(any_pop ? last_data : 8'h00));
      chk("idle_pc", 32'(p), 32'(any_pop ? last_pc : 8'h00));
    end
    if (ready_mode == 1)      r = 1'b1;
    else if (ready_mode == 2) r = ($urandom_range(0, 9) < 7);
    else                      r = 1'b0;
    bif.inst_ready = r;
    if (v && r) begin
      chk("pop_pc", 32'(p), 32'(exp_pc));
      chk("pop_data", 32'(d), 32'(mem[exp_pc]));
      exp_pc = next_flow(exp_pc, mem[exp_pc]);
      pops++;
      any_pop   = 1'b1;
      last_data = d;
      last_pc   = p;
      pop_pc_q.push_back(p);
    end
    prev_valid = v;
    prev_ready = r;
    prev_data  = d;
    prev_pc    = p;
    cyc++;
  endtask

  // Reset asserted mid-cycle; released just after a rising edge so cycle 0 is the
  // first cycle with a request on the bus.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_req", 32'(bif.imem_req), 32'd0);
    chk("rst_valid", 32'(bif.inst_valid), 32'd0);
    chk("rst_pc", 32'(bif.inst_pc), 32'd0);
    chk("rst_data", 32'(bif.inst_data), 32'd0);
    bif.inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    exp_pc = 8'h00; prev_valid = 1'b0; prev_ready = 1'b0; any_pop = 1'b0;
    cyc = 0; pops = 0; reqs = 0;
    pop_pc_q.delete();
    #2 rst = 1'b0;
    #1;
    chk("first_req", 32'(bif.imem_req), 32'd1);
    chk("first_addr", 32'(bif.imem_addr), 32'h00);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) & 8'h3F;
    mem[0] = 8'h09; mem[1] = 8'h12; mem[2] = 8'h1B; mem[3] = 8'h24;
  endtask

  initial begin
    int  n;
    bit  found;
    bif.inst_ready = 1'b0;
    ready_mode = 0;
    cyc = 0; pops = 0; reqs = 0; exp_pc = 0;
    prev_valid = 0; prev_ready = 0; any_pop = 0; last_data = 0; last_pc = 0;
    prev_data = 0; prev_pc = 0;
    repeat (2) @(posedge clk);

    // Straight line then jump at pc 5 to 6'h22.
    fill_linear();
    mem[5] = 8'hE2;
    ready_mode = 1;
    do_reset();
    repeat (30) step();
    chk("sl_valid_c1", 32'(log_valid[1]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("sl_valid", 32'(log_valid[2+i]), 32'd1);
      chk("sl_pc", 32'(log_pc[2+i]), 32'(i));
    end
    chk("sl_data0", 32'(log_data[2]), 32'h09);
    chk("sl_data1", 32'(log_data[3]), 32'h12);
    chk("sl_data2", 32'(log_data[4]), 32'h1B);
    chk("sl_data3", 32'(log_data[5]), 32'h24);
    chk("jmp_data", 32'(log_data[7]), 32'hE2);
    chk("killed_req", 32'(log_req[6]), 32'd1);
    chk("killed_addr", 32'(log_addr[6]), 32'h06);
    chk("jmp_bubble", 32'(log_valid[8]), 32'd0);
    chk("jmp_tgt_valid", 32'(log_valid[9]), 32'd1);
    chk("jmp_tgt_pc", 32'(log_pc[9]), 32'h22);

    // Back-pressure: decode stalls for 10 cycles.
    fill_linear();
    ready_mode = 0;
    do_reset();
    repeat (10) step();
    n = 0;
    for (int i = 0; i < 10; i++) if (log_req[i]) n++;
    chk("bp_req_count", 32'(n), 32'd4);
    chk("bp_req_stopped", 32'(log_req[9]), 32'd0);
    chk("bp_head_valid", 32'(log_valid[9]), 32'd1);
    chk("bp_head_data", 32'(log_data[9]), 32'h09);
    chk("bp_head_pc", 32'(log_pc[9]), 32'h00);
    ready_mode = 1;
    repeat (12) step();
    found = 1'b0;
    for (int i = 10; i < 22; i++) begin
      if (!found && log_req[i]) begin
        found = 1'b1;
        chk("bp_resume_addr", 32'(log_addr[i]), 32'h04);
      end
    end
    chk("bp_resume_seen", 32'(found), 32'd1);
    chk("bp_drain_count", 32'(pop_pc_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < pop_pc_q.size()) chk("bp_drain_pc", 32'(pop_pc_q[i]), 32'(i));

    // Jump chain crossing the upper PC bits, then sequential wrap 8'hFF -> 8'h00.
    fill_linear();
    mem[8'h00] = 8'hFF; mem[8'h3F] = 8'hFF; mem[8'h7F] = 8'hFF; mem[8'hBF] = 8'hFF;
    mem[8'hFF] = 8'h01;
    ready_mode = 1;
    do_reset();
    repeat (40) step();
    chk("wrap_len", 32'(pop_pc_q.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++)
      if (i < pop_pc_q.size()) chk("wrap_pc", 32'(pop_pc_q[i]), 32'(wrap_exp[i]));

    // Randomized program and decode back-pressure.
    for (int i = 0; i < 256; i++)
      mem[i] = {(($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2))), 6'($urandom)};
    ready_mode = 2;
    do_reset();
    repeat (3000) step();
    chk("rand_progress", 32'(pops > 1000), 32'd1);
    ready_mode = 0;
    repeat (12) step();
    chk("full_req_idle", 32'(bif.imem_req), 32'd0);
    chk("full_valid", 32'(bif.inst_valid), 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", 32'(fetch_cnt), 32'(pops + 4));
    chk("perf_kill_cnt", 32'(kill_cnt), 32'(reqs - (pops + 4)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
